// File: rtl/online_adder_serial.sv
// online_adder_serial: digit-serial, MSD-first radix-2 signed-digit online adder.
// LANES independent lanes run in lockstep under one valid/ready handshake.
// Each frame takes NDIG digits per operand and emits NDIG+1 sum digits
// (z_0 .. z_NDIG) with online delay 2.
// Digit encoding {p,n} has value p-n. Input code 11 is read as 0, and the
// output never produces 11.
// Optional build macro ONLINE_ADD_ERRCHK_EN enables the sticky invalid-code
// flag err. Without it, err is tied to 0.

module online_adder_serial #(
  parameter int NDIG  = 8,
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*LANES-1:0] x,
  input  logic [2*LANES-1:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*LANES-1:0] z,
  output logic               out_first,
  output logic               out_last,
  output logic               err
);

  localparam int CW = $clog2(NDIG + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_FLUSH1,
    S_FLUSH2
  } state_e;

  // Signed-digit code {p,n} to its value; 11 reads as 0.
  function automatic logic signed [2:0] dec(input logic [1:0] d);
    case (d)
      2'b10:   dec = 3'sd1;
      2'b01:   dec = -3'sd1;
      default: dec = 3'sd0;
    endcase
  endfunction

  // Transfer part of w = 2t + u. The lookahead on w_nxt keeps z in {-1,0,1}.
  function automatic logic signed [2:0] t_of(input logic signed [2:0] w,
                                             input logic signed [2:0] w_nxt);
    case (w)
      3'sd2:   t_of = 3'sd1;
      -3'sd2:  t_of = -3'sd1;
      3'sd1:   t_of = (w_nxt >= 3'sd0) ? 3'sd1 : 3'sd0;
      -3'sd1:  t_of = (w_nxt <= 3'sd0) ? -3'sd1 : 3'sd0;
      default: t_of = 3'sd0;
    endcase
  endfunction

  // Interim-sum part of w = 2t + u. This is the complement of t_of.
  function automatic logic signed [2:0] u_of(input logic signed [2:0] w,
                                             input logic signed [2:0] w_nxt);
    case (w)
      3'sd1:   u_of = (w_nxt >= 3'sd0) ? -3'sd1 : 3'sd1;
      -3'sd1:  u_of = (w_nxt <= 3'sd0) ? 3'sd1 : -3'sd1;
      default: u_of = 3'sd0;
    endcase
  endfunction

  // Sum digit value in {-1,0,1} back to the {p,n} code.
  function automatic logic [1:0] enc(input logic signed [2:0] s);
    case (s)
      3'sd1:   enc = 2'b10;
      -3'sd1:  enc = 2'b01;
      default: enc = 2'b00;
    endcase
  endfunction

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [LANES-1:0][2:0]     wm2_q, wm2_d;   // w_{j-2} per lane
  logic [LANES-1:0][2:0]     wm1_q, wm1_d;   // w_{j-1} per lane
  logic [2*LANES-1:0]        z_q, z_d;
  logic                      out_valid_q, out_valid_d;
  logic                      first_q, first_d;
  logic                      last_q, last_d;

  logic                      adv;
  logic                      in_phase;
  logic                      accept;
  logic                      step;
  logic                      emit;
  logic [LANES-1:0][2:0]     w_cur;
  logic [2*LANES-1:0]        z_step;

  // Handshake: a step fires on an accepted digit or on a flush beat.
  // Flush beats ignore in_valid.
  always_comb begin
    adv      = !out_valid_q || out_ready;
    in_phase = (state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_STREAM);
    in_ready = !rst && adv && in_phase;
    accept   = in_ready && in_valid;
    step     = accept || (adv && !in_phase);
    emit     = step && (state_q != S_IDLE);
  end

  // Per-lane datapath: z_{j-2} = u_{j-2} + t_{j-1}, with zero digits during flush.
  always_comb begin
    w_cur  = '0;
    z_step = '0;
    for (int k = 0; k < LANES; k++) begin
      w_cur[k] = in_phase ? (dec(x[2*k +: 2]) + dec(y[2*k +: 2])) : 3'sd0;
      z_step[2*k +: 2] = enc(u_of(wm2_q[k], wm1_q[k]) + t_of(wm1_q[k], w_cur[k]));
    end
  end

  // Next-state logic for the frame FSM, the digit history and the output register.
  always_comb begin
    // NOTE: every variable this block writes gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    wm2_d       = wm2_q;
    wm1_d       = wm1_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    first_d     = first_q;
    last_d      = last_q;

    if (step) begin
      wm2_d = wm1_q;
      wm1_d = w_cur;
      case (state_q)
        S_IDLE: begin
          state_d = S_FILL;
          cnt_d   = CW'(1);
        end
        S_FILL, S_STREAM: begin
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(NDIG - 1)) ? S_FLUSH1 : S_STREAM;
        end
        S_FLUSH1: begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_FLUSH2;
        end
        S_FLUSH2: begin
          cnt_d   = '0;
          state_d = S_IDLE;
          wm2_d   = '0;
          wm1_d   = '0;
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end

    if (emit) begin
      z_d         = z_step;
      out_valid_d = 1'b1;
      first_d     = (state_q == S_FILL);
      last_d      = (state_q == S_FLUSH2);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State, history and output registers. Reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      // NOTE: the lane history must be reset. Reset mid-frame would otherwise leak stale digits into the next frame's z_0.
      wm2_q       <= '0;
      wm1_q       <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wm2_q       <= wm2_d;
      wm1_q       <= wm1_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign out_first = first_q;
  assign out_last  = last_q;

`ifdef ONLINE_ADD_ERRCHK_EN
  logic err_q, err_d;
  logic bad_code;

  // Sticky flag for code 11 on an accepted beat. A clean frame start clears it.
  always_comb begin
    bad_code = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (x[2*k +: 2] == 2'b11 || y[2*k +: 2] == 2'b11) bad_code = 1'b1;
    end
    err_d = err_q;
    if (accept) begin
      if (bad_code)                 err_d = 1'b1;
      else if (state_q == S_IDLE)   err_d = 1'b0;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_online_adder_serial.sv
// Directed bench for online_adder_serial with NDIG=4 and LANES=2.
// Each vector record holds per-lane operand digits and hand-computed sum digits.
// Records run singly, back to back, and under output backpressure.
// Hand-written sequences cover reset and the error flag.

module tb_online_adder_serial;

  localparam int NDIG  = 4;
  localparam int LANES = 2;
  localparam int NOUT  = NDIG + 1;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] O = 2'b00;
  localparam logic [1:0] B = 2'b11;
`ifdef ONLINE_ADD_ERRCHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                out_ready = 1'b0;
  logic [2*LANES-1:0]  x = '0;
  logic [2*LANES-1:0]  y = '0;
  logic                in_ready;
  logic                out_valid;
  logic [2*LANES-1:0]  z;
  logic                out_first;
  logic                out_last;
  logic                err;

  online_adder_serial #(.NDIG(NDIG), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .out_first (out_first),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] x0 [NDIG];
    logic [1:0] y0 [NDIG];
    logic [1:0] x1 [NDIG];
    logic [1:0] y1 [NDIG];
    logic [1:0] z0 [NOUT];
    logic [1:0] z1 [NOUT];
  } vec_t;

  typedef struct {
    logic [3:0] zd;
    logic       first;
    logic       last;
  } exp_t;

  vec_t       vt [8];
  exp_t       expq [$];
  logic [3:0] sx [$];
  logic [3:0] sy [$];
  int         acc_cyc [$];
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Runs frames vt[first .. first+n-1] back to back.
  // mode 0: out_ready held high. mode 1: out_ready cycles 1,0,0,1.
  // probe: once all digits are in, keep in_valid high and require in_ready low.
  task automatic run_seq(input int first, input int n, input int mode, input bit probe);
    int   cyc;
    int   got;
    int   sidx;
    logic pv;
    logic pr;
    logic hf;
    logic hl;
    logic [3:0] hz;
    exp_t e;
    expq.delete();
    sx.delete();
    sy.delete();
    acc_cyc.delete();
    for (int f = first; f < first + n; f++) begin
      for (int j = 0; j < NDIG; j++) begin
        sx.push_back({vt[f].x1[j], vt[f].x0[j]});
        sy.push_back({vt[f].y1[j], vt[f].y0[j]});
      end
      for (int k = 0; k < NOUT; k++) begin
        e.zd    = {vt[f].z1[k], vt[f].z0[k]};
        e.first = (k == 0);
        e.last  = (k == NOUT - 1);
        expq.push_back(e);
      end
    end
    cyc = 0; got = 0; sidx = 0; pv = 1'b0; pr = 1'b0; hz = '0; hf = 1'b0; hl = 1'b0;
    while (got < n * NOUT && cyc < 200) begin
      @(negedge clk);
      cyc++;
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 1) || (cyc % 4 == 0));
      if (pv && !pr)
        check("stall_hold", {out_valid, z, out_first, out_last}, {1'b1, hz, hf, hl});
      if (out_valid && out_ready) begin
        e = expq.pop_front();
        check($sformatf("frame%0d_z%0d", first + got / NOUT, got % NOUT),
              {z, out_first, out_last}, {e.zd, e.first, e.last});
        got++;
      end
      pv = out_valid; pr = out_ready; hz = z; hf = out_first; hl = out_last;
      if (sidx < sx.size()) begin
        in_valid = 1'b1; x = sx[sidx]; y = sy[sidx];
      end else if (probe && got < n * NOUT) begin
        in_valid = 1'b1; x = {P, P}; y = {P, P};
      end else begin
        in_valid = 1'b0; x = '0; y = '0;
      end
      #1;
      if (in_valid) begin
        if (sidx < sx.size()) begin
          if (in_ready) begin
            acc_cyc.push_back(cyc);
            sidx++;
          end
        end else begin
          check("flush_hold", in_ready, 1'b0);
        end
      end
    end
    in_valid = 1'b0; x = '0; y = '0;
    if (got < n * NOUT) check("timeout_outputs", got, n * NOUT);
    if (mode == 0 && acc_cyc.size() == n * NDIG) begin
      for (int f = 0; f < n - 1; f++)
        check("frame_gap", acc_cyc[(f + 1) * NDIG] - acc_cyc[f * NDIG + NDIG - 1], 3);
    end
  endtask

  initial begin
    // 0: lane0 1.0 + 0 ... -> 1,0,0,0,0 ; lane1 all zero
    vt[0].x0 = '{P, O, O, O}; vt[0].y0 = '{P, O, O, O}; vt[0].z0 = '{P, O, O, O, O};
    vt[0].x1 = '{O, O, O, O}; vt[0].y1 = '{O, O, O, O}; vt[0].z1 = '{O, O, O, O, O};
    // 1: lane0 0.75 -> 1,0,-1,0,0
    vt[1].x0 = '{P, P, O, O}; vt[1].y0 = '{O, O, O, O}; vt[1].z0 = '{P, O, M, O, O};
    vt[1].x1 = '{O, O, O, O}; vt[1].y1 = '{O, O, O, O}; vt[1].z1 = '{O, O, O, O, O};
    // 2: lane0 0.6875 -> 1,0,-1,-1,1
    vt[2].x0 = '{P, O, O, M}; vt[2].y0 = '{O, P, O, O}; vt[2].z0 = '{P, O, M, M, P};
    vt[2].x1 = '{O, O, O, O}; vt[2].y1 = '{O, O, O, O}; vt[2].z1 = '{O, O, O, O, O};
    // 3: lane0 as vector 0, lane1 -1.875 -> -1,-1,-1,-1,0
    vt[3].x0 = '{P, O, O, O}; vt[3].y0 = '{P, O, O, O}; vt[3].z0 = '{P, O, O, O, O};
    vt[3].x1 = '{M, M, M, M}; vt[3].y1 = '{M, M, M, M}; vt[3].z1 = '{M, M, M, M, O};
    // 4: lane0 0.75, lane1 0.6875 (lanes swapped in role)
    vt[4].x0 = '{P, P, O, O}; vt[4].y0 = '{O, O, O, O}; vt[4].z0 = '{P, O, M, O, O};
    vt[4].x1 = '{P, O, O, M}; vt[4].y1 = '{O, P, O, O}; vt[4].z1 = '{P, O, M, M, P};
    // 5: lane0 -0.375 (w=-1 then later w=1), lane1 -0.25 (w=-1 with next w>0)
    vt[5].x0 = '{M, O, P, O}; vt[5].y0 = '{O, O, O, O}; vt[5].z0 = '{M, P, P, M, O};
    vt[5].x1 = '{M, P, O, O}; vt[5].y1 = '{O, O, O, O}; vt[5].z1 = '{O, O, M, O, O};
    // 6: lane0 0.25 (w=1 with next w<0), lane1 w=2 in the last digit -> 0.125
    vt[6].x0 = '{P, M, O, O}; vt[6].y0 = '{O, O, O, O}; vt[6].z0 = '{O, O, P, O, O};
    vt[6].x1 = '{O, O, O, P}; vt[6].y1 = '{O, O, O, P}; vt[6].z1 = '{O, O, O, P, O};
    // 7: lane0 x2 carries code 11 (read as 0) -> w=1,0,0,0 -> 1,-1,0,0,0
    vt[7].x0 = '{P, B, O, O}; vt[7].y0 = '{O, O, O, O}; vt[7].z0 = '{P, M, O, O, O};
    vt[7].x1 = '{O, O, O, O}; vt[7].y1 = '{O, O, O, O}; vt[7].z1 = '{O, O, O, O, O};

    // Reset state with out_ready high, so only reset can hold in_ready low.
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_outputs", {out_valid, z, out_first, out_last, err}, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1'b1);

    // Single frames at full rate, with a flush hold-off probe on the third.
    run_seq(0, 1, 0, 1'b0);
    run_seq(1, 1, 0, 1'b0);
    run_seq(2, 1, 0, 1'b1);

    // Backpressure, then back-to-back frames with and without stalls.
    run_seq(2, 1, 1, 1'b1);
    run_seq(0, 3, 0, 1'b0);
    run_seq(0, 3, 1, 1'b0);

    // Two-lane and lookahead-path vectors, back to back.
    run_seq(3, 4, 0, 1'b0);

    // Reset after the third accepted digit abandons the frame.
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      x = {vt[2].x1[j], vt[2].x0[j]};
      y = {vt[2].y1[j], vt[2].y0[j]};
      #1;
      check("pre_rst_accept", in_ready, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0; x = '0; y = '0;
    check("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", {out_valid, z, out_first, out_last}, '0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_quiet", out_valid, 1'b0);
    end
    run_seq(2, 1, 0, 1'b0);

    // Invalid code: z treats 11 as 0. err is sticky until a clean frame start.
    run_seq(7, 1, 0, 1'b0);
    check("err_sticky", err, ERR_EN);
    @(negedge clk);
    check("err_held", err, ERR_EN);
    run_seq(0, 1, 0, 1'b0);
    check("err_cleared", err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
